// File: rtl/fpu_add_sub_sorter_pkg.sv
// Shared FP16 types and constants used across the FPU add/sub datapath stages.
package fpu_add_sub_sorter_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t      FP16_QNAN    = 16'h7E00;
    localparam fp16_t      FP16_ZERO    = 16'h0000;
    localparam logic [4:0] FP16_EXP_MAX = 5'd31;

    // Flipping the sign bit turns A+B into A-B without touching the magnitude.
    function automatic fp16_t fp16Negate(input fp16_t value, input logic doNegate);
        return {value[15] ^ doNegate, value[14:0]};
    endfunction

endpackage

// File: rtl/fpu_add_sub_sorter_classify.sv
// Combinational FP16 class detection on the magnitude bits; sign plays no part here.
module fp16_classify
    import fpu_add_sub_sorter_pkg::*;
(
    input  logic [14:0] magnitude,
    output logic        isNaN,
    output logic        isInf,
    output logic        isZero
);

    logic expAllOnes;
    logic mantIsZero;

    always_comb begin
        expAllOnes = (magnitude[14:10] == FP16_EXP_MAX);
        mantIsZero = (magnitude[9:0] == 10'd0);
        isNaN      = expAllOnes && !mantIsZero;
        isInf      = expAllOnes && mantIsZero;
        isZero     = (magnitude == 15'd0);
    end

endmodule

// File: rtl/fpu_add_sub_sorter.sv
// Front end of the FP16 adder: orders the effective operands by magnitude and
// resolves NaN/Inf results early so the aligner and adder can be bypassed.
module fpu_add_sub_sorter
    import fpu_add_sub_sorter_pkg::*;
(
    input  logic  clock,
    input  logic  reset_L,
    input  logic  in_valid,
    output logic  in_ready,
    input  fp16_t opA,
    input  fp16_t opB,
    input  logic  sub,
    output logic  out_valid,
    input  logic  out_ready,
    output fp16_t largeNum,
    output fp16_t smallNum,
    output logic  effSub,
    output logic  swapped,
    output logic  special,
    output fp16_t specialResult
);

    fp16_t effB;
    logic  aIsNaN, aIsInf, bIsNaN, bIsInf;
    logic  unusedZeroA, unusedZeroB;

    logic  s1Valid_q;
    fp16_t s1A_q, s1B_q;
    logic  s1ANaN_q, s1AInf_q, s1BNaN_q, s1BInf_q;

    logic  s2Valid_q;
    fp16_t s2Large_q, s2Small_q, s2SpecRes_q;
    logic  s2EffSub_q, s2Swapped_q, s2Special_q;

    fp16_t s2Large_d, s2Small_d, s2SpecRes_d;
    logic  s2EffSub_d, s2Swapped_d, s2Special_d;

    logic  s2Advance;

    assign effB = fp16Negate(opB, sub);

    fp16_classify uClassA (
        .magnitude (opA[14:0]),
        .isNaN     (aIsNaN),
        .isInf     (aIsInf),
        .isZero    (unusedZeroA)
    );

    fp16_classify uClassB (
        .magnitude (effB[14:0]),
        .isNaN     (bIsNaN),
        .isInf     (bIsInf),
        .isZero    (unusedZeroB)
    );

    // S1 only ever moves into S2, so S1 drains exactly when S2 advances.
    assign s2Advance = !s2Valid_q || out_ready;
    assign in_ready  = !s1Valid_q || s2Advance;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= FP16_ZERO;
            s1B_q     <= FP16_ZERO;
            s1ANaN_q  <= 1'b0;
            s1AInf_q  <= 1'b0;
            s1BNaN_q  <= 1'b0;
            s1BInf_q  <= 1'b0;
        end else if (in_ready) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1A_q    <= opA;
                s1B_q    <= effB;
                s1ANaN_q <= aIsNaN;
                s1AInf_q <= aIsInf;
                s1BNaN_q <= bIsNaN;
                s1BInf_q <= bIsInf;
            end
        end
    end

    // Ties keep A on top so equal magnitudes never report a swap.
    always_comb begin
        s2Swapped_d = (s1B_q[14:0] > s1A_q[14:0]);
        s2Large_d   = s2Swapped_d ? s1B_q : s1A_q;
        s2Small_d   = s2Swapped_d ? s1A_q : s1B_q;
        s2EffSub_d  = s1A_q[15] ^ s1B_q[15];
        s2Special_d = 1'b0;
        s2SpecRes_d = FP16_ZERO;
        if (s1ANaN_q || s1BNaN_q || (s1AInf_q && s1BInf_q && s2EffSub_d)) begin
            s2Special_d = 1'b1;
            s2SpecRes_d = FP16_QNAN;
        end else if (s1AInf_q) begin
            s2Special_d = 1'b1;
            s2SpecRes_d = s1A_q;
        end else if (s1BInf_q) begin
            s2Special_d = 1'b1;
            s2SpecRes_d = s1B_q;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            s2Valid_q   <= 1'b0;
            s2Large_q   <= FP16_ZERO;
            s2Small_q   <= FP16_ZERO;
            s2SpecRes_q <= FP16_ZERO;
            s2EffSub_q  <= 1'b0;
            s2Swapped_q <= 1'b0;
            s2Special_q <= 1'b0;
        end else if (s2Advance) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Large_q   <= s2Large_d;
                s2Small_q   <= s2Small_d;
                s2SpecRes_q <= s2SpecRes_d;
                s2EffSub_q  <= s2EffSub_d;
                s2Swapped_q <= s2Swapped_d;
                s2Special_q <= s2Special_d;
            end
        end
    end

    assign out_valid     = s2Valid_q;
    assign largeNum      = s2Large_q;
    assign smallNum      = s2Small_q;
    assign effSub        = s2EffSub_q;
    assign swapped       = s2Swapped_q;
    assign special       = s2Special_q;
    assign specialResult = s2SpecRes_q;

endmodule

// File: tb/tb_fpu_add_sub_sorter.sv
// Directed bench for the FP16 add/sub operand sorter: latency, throughput,
// back-pressure hold, NaN/Inf handling and mid-flight reset.
module tb_fpu_add_sub_sorter;

    logic        clock;
    logic        reset_L;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] largeNum;
    logic [15:0] smallNum;
    logic        effSub;
    logic        swapped;
    logic        special;
    logic [15:0] specialResult;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] lg;
        logic [15:0] sm;
        logic        es;
        logic        sw;
        logic        sp;
        logic [15:0] sr;
    } vec_t;

    vec_t vecs[13];
    vec_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc;

    fpu_add_sub_sorter dut (
        .clock         (clock),
        .reset_L       (reset_L),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opA           (opA),
        .opB           (opB),
        .sub           (sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .largeNum      (largeNum),
        .smallNum      (smallNum),
        .effSub        (effSub),
        .swapped       (swapped),
        .special       (special),
        .specialResult (specialResult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic applyStimulus(input vec_t v, output int cycles);
        logic acc;
        cycles   = 0;
        in_valid = 1'b1;
        opA      = v.a;
        opB      = v.b;
        sub      = v.s;
        acc      = 1'b0;
        while (!acc && cycles < 50) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            cycles++;
            if (acc) expQ.push_back(v);
        end
        if (!acc) checkOutput("acceptTimeout", 16'd0, 16'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainWait();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drainTimeout", 16'(expQ.size()), 16'd0);
        @(posedge clock);
        #1;
    endtask

    // Outputs must match the oldest outstanding expectation whether or not they are consumed.
    always @(negedge clock) begin
        if (reset_L && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedOut", 16'd1, 16'd0);
            end else begin
                checkOutput("largeNum", largeNum, expQ[0].lg);
                checkOutput("smallNum", smallNum, expQ[0].sm);
                checkOutput("effSub", {15'd0, effSub}, {15'd0, expQ[0].es});
                checkOutput("swapped", {15'd0, swapped}, {15'd0, expQ[0].sw});
                checkOutput("special", {15'd0, special}, {15'd0, expQ[0].sp});
                checkOutput("specialResult", specialResult, expQ[0].sr);
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        //            a        b        s     large    small    es    sw    sp    specRes
        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4000, 16'h3C00, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h3C00, 16'hBC00, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E01, 16'h3C00, 1'b0, 1'b0, 1'b1, 16'h7E00};
        vecs[3]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7C00, 16'hFC00, 1'b1, 1'b0, 1'b1, 16'h7E00};
        vecs[4]  = '{16'hC500, 16'h4200, 1'b0, 16'hC500, 16'h4200, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{16'h8000, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 16'h3C00, 1'b1, 1'b1, 1'b1, 16'hFC00};
        vecs[8]  = '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 16'h4000, 1'b1, 1'b0, 1'b1, 16'hFC00};
        vecs[9]  = '{16'h7C00, 16'hFC00, 1'b1, 16'h7C00, 16'h7C00, 1'b0, 1'b0, 1'b1, 16'h7C00};
        vecs[10] = '{16'h3C00, 16'hFE00, 1'b1, 16'h7E00, 16'h3C00, 1'b0, 1'b1, 1'b1, 16'h7E00};
        vecs[11] = '{16'h03FF, 16'h0400, 1'b0, 16'h0400, 16'h03FF, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[12] = '{16'h7BFF, 16'hFBFF, 1'b0, 16'h7BFF, 16'hFBFF, 1'b1, 1'b0, 1'b0, 16'h0000};

        reset_L   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opA       = 16'h0;
        opB       = 16'h0;
        sub       = 1'b0;
        #1 reset_L = 1'b0;
        #2;
        checkOutput("rstOutValid", {15'd0, out_valid}, 16'd0);
        checkOutput("rstLargeNum", largeNum, 16'h0000);
        checkOutput("rstSpecialResult", specialResult, 16'h0000);
        checkOutput("rstSpecial", {15'd0, special}, 16'd0);
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;
        @(negedge clock);
        checkOutput("rstInReady", {15'd0, in_ready}, 16'd1);
        @(posedge clock);
        #1;

        // Single transfer with exact two-cycle latency.
        applyStimulus(vecs[0], cyc);
        @(negedge clock);
        checkOutput("latencyCycle1", {15'd0, out_valid}, 16'd0);
        @(negedge clock);
        checkOutput("latencyCycle2", {15'd0, out_valid}, 16'd1);
        @(posedge clock);
        #1;
        drainWait();

        for (int i = 1; i < 4; i++) begin
            applyStimulus(vecs[i], cyc);
            drainWait();
        end

        // Streaming: one accept per cycle with the sink always ready.
        for (int i = 4; i < 13; i++) begin
            applyStimulus(vecs[i], cyc);
            checkOutput("streamAcceptCycles", 16'(cyc), 16'd1);
        end
        drainWait();

        // Back-pressure: two fill the pipe, the third waits until the sink frees up.
        out_ready = 1'b0;
        applyStimulus(vecs[0], cyc);
        applyStimulus(vecs[1], cyc);
        in_valid = 1'b1;
        opA      = vecs[2].a;
        opB      = vecs[2].b;
        sub      = vecs[2].s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("stallInReady", {15'd0, in_ready}, 16'd0);
            checkOutput("stallOutValid", {15'd0, out_valid}, 16'd1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(vecs[2], cyc);
        checkOutput("resumeAcceptCycles", 16'(cyc), 16'd1);
        drainWait();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        applyStimulus(vecs[5], cyc);
        applyStimulus(vecs[6], cyc);
        #2 reset_L = 1'b0;
        #1;
        checkOutput("midRstOutValid", {15'd0, out_valid}, 16'd0);
        checkOutput("midRstLargeNum", largeNum, 16'h0000);
        checkOutput("midRstSmallNum", smallNum, 16'h0000);
        checkOutput("midRstEffSub", {15'd0, effSub}, 16'd0);
        checkOutput("midRstSwapped", {15'd0, swapped}, 16'd0);
        expQ.delete();
        @(posedge clock);
        #1;
        reset_L   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("postRstInReady", {15'd0, in_ready}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("postRstNoStale", {15'd0, out_valid}, 16'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        applyStimulus(vecs[7], cyc);
        drainWait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
